apb_master_n: RTL and testbench
===============================

# apb_master_n

Parametrised APB master bridge. It converts a valid/ready command interface into APB SETUP/ACCESS transfers to one of `NUM_SLV` slaves, selected from the upper address bits. It muxes slave `PRDATA`/`PREADY`/`PSLVERR` internally and returns a one-cycle response with read data and error status. Over the current two-slave master, it adds configurable width and slave count, wait-state tolerance with timeout, a per-slave `PSLVERR` path and decode-error reporting. It sits between the system command source and the APB slave bank.

## Interface
Parameters:
- `ADDR_W`, 8: APB address width; the top `SEL_W` bits select the slave.
- `DATA_W`, 8: APB data width.
- `NUM_SLV`, 4: number of slaves, 2..16.
- `SEL_W`, `$clog2(NUM_SLV)` (derived, not overridable): slave-select field width.
- `TIMEOUT`, 15: maximum tolerated wait states per transfer; 0 disables the timeout.

Ports:
- `PCLK`  in  1  clock; all logic is on the rising edge.
- `PRESET`  in  1  reset; one clock, reset is synchronous and active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high in IDLE while `PRESET`=1.
- `cmd_write`  in  1  1=write, 0=read.
- `cmd_addr`  in  `ADDR_W`  target address.
- `cmd_wdata`  in  `DATA_W`  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  `DATA_W`  read data; 0 for writes and errors.
- `rsp_err`  out  1  slave error, timeout or decode error.
- `PSEL`  out  `NUM_SLV`  one-hot slave select.
- `PENABLE`, `PWRITE`  out  1  APB controls.
- `PADDR`  out  `ADDR_W`  APB address.
- `PWDATA`  out  `DATA_W`  APB write data.
- `PRDATA`  in  `NUM_SLV*DATA_W`  flattened; slave k occupies bits [k*DATA_W +: DATA_W].
- `PREADY`, `PSLVERR`  in  `NUM_SLV`  per-slave ready and error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - A command is accepted when `cmd_valid`&`cmd_ready` at a clock edge.
  - Address, data and direction are registered.
  - Slave index = `cmd_addr[ADDR_W-1 -: SEL_W]`.
- **Decode error** (index ≥ `NUM_SLV`):
  - Stay in IDLE; no APB signal changes.
  - Next cycle: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
- **SETUP** (exactly one cycle):
  - `PSEL[k]`=1, `PENABLE`=0.
  - `PADDR`/`PWRITE`/`PWDATA` hold the registered command.
  - Always proceeds to ACCESS.
- **ACCESS:**
  - `PENABLE`=1; all other APB outputs are held stable.
  - Each cycle with `PREADY[k]`=0 increments the wait counter (width `$clog2(TIMEOUT+1)`, minimum 1).
  - **Completion:** `PREADY[k]`=1 at an edge.
    - Capture `PRDATA[k]` (reads only) and `PSLVERR[k]`.
    - Go to IDLE.
    - `PSEL`/`PENABLE` = 0 next cycle.
    - `rsp_valid`=1 the same next cycle, with `rsp_err`=`PSLVERR[k]`.
    - If `rsp_err`=1, `rsp_rdata` is forced to 0.
  - **Timeout:** `TIMEOUT`≠0, wait counter = `TIMEOUT`, and `PREADY[k]` still 0 at an edge.
    - Abort to IDLE.
    - Response has `rsp_err`=1, `rsp_rdata`=0.
- **Simultaneous events:**
  - `PREADY[k]`=1 on the last allowed cycle is a normal completion, not a timeout.
  - Signals of unselected slaves are ignored entirely.
- **Reset values** (`PRESET`=0 at an edge; all outputs):
  - `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PADDR`=0, `PWDATA`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0; state IDLE; wait counter 0.
  - `cmd_ready`=0 while `PRESET`=0.
  - Reset during SETUP/ACCESS aborts the transfer silently; no response is issued for it.

## Timing
- **Zero-wait transfer:**
  - Accept at edge t0.
  - SETUP in cycle t0+1, ACCESS in t0+2.
  - `rsp_valid` in t0+3, when `cmd_ready` is already high again.
  - Throughput is one transfer per 3 cycles.
- **Wait states:** W wait states (W ≤ `TIMEOUT`) put `rsp_valid` at t0+3+W.
- **Timeout:** `rsp_valid`, `rsp_err`=1 at t0+3+`TIMEOUT`.
- **Decode error:** `rsp_valid` at t0+1.
- `rsp_*` are registered outputs, valid only during the `rsp_valid` cycle and held at their last values otherwise.
- `PADDR`/`PWRITE`/`PWDATA` change only on acceptance.

## Structure
- Package `apb_pkg`:
  - `apb_state_t` enum (IDLE, SETUP, ACCESS).
  - Localparam for the maximum `NUM_SLV`.
- Sub-module `apb_decoder`: combinational; address → one-hot select plus `dec_err`, parametrised on `ADDR_W`/`NUM_SLV`.
- Response mux and wait counter live in the top level.

## Test plan
- **Write/read, zero wait:** `NUM_SLV`=4, `ADDR_W`=8. Write 0xA5 to 0x43 (slave 1), then read 0x43.
  - `PSEL`=4'b0010 for one SETUP and one ACCESS cycle.
  - Read `rsp_rdata`=0xA5, `rsp_err`=0, `rsp_valid` at t0+3.
- **Wait states:** slave 2 holds `PREADY` low for 3 cycles on a read of 0x80.
  - `PENABLE` high for 4 cycles; `rsp_valid` at t0+6; correct data returned.
- **Timeout:** `TIMEOUT`=15, slave never ready.
  - `rsp_valid`, `rsp_err`=1, `rsp_rdata`=0 at t0+18.
  - A slave ready after exactly 15 waits completes with no error.
- **Slave error and decode error:**
  - `PSLVERR[0]`=1 with `PREADY` on a read → `rsp_err`=1, `rsp_rdata`=0.
  - `NUM_SLV`=3, `cmd_addr`=0xC0 → no `PSEL` activity; `rsp_err`=1 at t0+1.
- **Reset mid-ACCESS:** `PRESET`=0 at t0+2.
  - All outputs 0 next cycle; no `rsp_valid`.
  - After release, a fresh write to slave 3 completes normally.
- **Back-to-back:** `cmd_valid` held high for 6 writes to slave 0, addresses 0x00–0x05, data i*i.
  - Accepted every 3 cycles; 6 `rsp_valid` pulses.
  - Read-back returns 0,1,4,9,16,25.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and limits for the parametrised APB master bridge.
//   apb_state_t  - bridge FSM states (IDLE, SETUP, ACCESS)
//   APB_MAX_SLV  - largest supported slave count
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int APB_MAX_SLV = 16;

endpackage

// File: rtl/apb_decoder.sv
// apb_decoder: combinational slave decode from the upper address bits.
//   addr    in   ADDR_W   command address
//   sel     out  NUM_SLV  one-hot slave select (all zero on decode error)
//   dec_err out  1        select field addresses a slave that does not exist
module apb_decoder #(
   parameter int ADDR_W  = 8,
   parameter int NUM_SLV = 4
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic [NUM_SLV-1:0] sel,
   output logic               dec_err
);

   localparam int SEL_W = $clog2(NUM_SLV);

   logic [SEL_W-1:0] idx;

   assign idx = addr[ADDR_W-1 -: SEL_W];

   always_comb begin
      sel = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (idx == SEL_W'(k)) sel[k] = 1'b1;
      end
      // Only reachable when NUM_SLV is not a power of two.
      dec_err = (int'(idx) >= NUM_SLV);
   end

endmodule

// File: rtl/apb_master_n.sv
// apb_master_n: valid/ready command to APB bridge for NUM_SLV slaves.
//   PCLK, PRESET                 clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata   command in (accepted in IDLE)
//   rsp_valid/rdata/err          registered one-cycle completion
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB requester outputs
//   PRDATA/PREADY/PSLVERR        per-slave APB returns (PRDATA flattened)
module apb_master_n
   import apb_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int NUM_SLV = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                        PCLK,
   input  logic                        PRESET,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [ADDR_W-1:0]           cmd_addr,
   input  logic [DATA_W-1:0]           cmd_wdata,
   output logic                        rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        rsp_err,
   output logic [NUM_SLV-1:0]          PSEL,
   output logic                        PENABLE,
   output logic                        PWRITE,
   output logic [ADDR_W-1:0]           PADDR,
   output logic [DATA_W-1:0]           PWDATA,
   input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
   input  logic [NUM_SLV-1:0]          PREADY,
   input  logic [NUM_SLV-1:0]          PSLVERR
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   if (NUM_SLV < 2 || NUM_SLV > APB_MAX_SLV) begin : g_bad_num_slv
      $error("apb_master_n: NUM_SLV out of range");
   end

   apb_state_t         state;
   logic [CNT_W-1:0]   wcnt;
   logic [NUM_SLV-1:0] dec_sel;
   logic               dec_err;
   logic               accept;
   logic               sel_rdy;
   logic               sel_err;
   logic [DATA_W-1:0]  sel_rdata;

   apb_decoder #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) u_dec (
      .addr    (cmd_addr),
      .sel     (dec_sel),
      .dec_err (dec_err)
   );

   assign cmd_ready = (state == IDLE) && PRESET;
   assign accept    = cmd_valid && cmd_ready;

   // PSEL is one-hot during a transfer, so gating each slave by its own
   // select bit both muxes and ignores everything from unselected slaves.
   always_comb begin
      sel_rdy   = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (PSEL[k]) begin
            sel_rdy   = sel_rdy | PREADY[k];
            sel_err   = sel_err | PSLVERR[k];
            sel_rdata = sel_rdata | PRDATA[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         state     <= IDLE;
         wcnt      <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (dec_err) begin
                     // Answered locally; the APB bus never sees it.
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     PSEL   <= dec_sel;
                     PADDR  <= cmd_addr;
                     PWRITE <= cmd_write;
                     PWDATA <= cmd_wdata;
                     state  <= SETUP;
                  end
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               wcnt    <= '0;
               state   <= ACCESS;
            end
            ACCESS: begin
               // Ready wins over timeout on the last allowed cycle.
               if (sel_rdy) begin
                  PSEL      <= '0;
                  PENABLE   <= 1'b0;
                  state     <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= sel_err;
                  rsp_rdata <= (PWRITE || sel_err) ? '0 : sel_rdata;
               end else if (TIMEOUT != 0 && wcnt == CNT_MAX) begin
                  PSEL      <= '0;
                  PENABLE   <= 1'b0;
                  state     <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else if (TIMEOUT != 0) begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_n.sv
module tb_apb_master_n;
   localparam int TO = 15;

   logic        PCLK = 0;
   logic        PRESET = 0;
   logic        cmd_valid = 0, cmd_write = 0;
   logic [7:0]  cmd_addr = 0, cmd_wdata = 0;
   logic        cmd_ready, rsp_valid, rsp_err;
   logic [7:0]  rsp_rdata;
   logic [3:0]  PSEL;
   logic        PENABLE, PWRITE;
   logic [7:0]  PADDR, PWDATA;
   logic [31:0] PRDATA;
   logic [3:0]  PREADY, PSLVERR;

   // three-slave instance for decode-error coverage; slaves always ready
   logic        c_valid = 0, c_write = 0;
   logic [7:0]  c_addr = 0, c_wdata = 0;
   logic        c_ready, r_valid, r_err;
   logic [7:0]  r_rdata;
   logic [2:0]  psel3;
   logic        pen3, pwr3;
   logic [7:0]  paddr3, pwdata3;
   logic [23:0] prdata3 = 24'h121110;
   logic [2:0]  pready3 = 3'b111, pslverr3 = 3'b000;

   int checks = 0, failures = 0;

   always #5 PCLK = ~PCLK;

   apb_master_n #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(4), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   apb_master_n #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(TO)) dut3 (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(c_valid), .cmd_ready(c_ready), .cmd_write(c_write),
      .cmd_addr(c_addr), .cmd_wdata(c_wdata),
      .rsp_valid(r_valid), .rsp_rdata(r_rdata), .rsp_err(r_err),
      .PSEL(psel3), .PENABLE(pen3), .PWRITE(pwr3), .PADDR(paddr3), .PWDATA(pwdata3),
      .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
   );

   // ---------------- slave bank behaviour ----------------
   int          tgt_wait = 0;
   logic        tgt_err = 0;
   int          acnt = 0;
   logic [3:0]  nz_rdy = 0, nz_err = 0;
   logic [31:0] nz_dat = 0;
   logic [7:0]  bfm_mem [256] = '{default: 8'h00};

   always @(negedge PCLK) begin
      nz_rdy <= 4'($urandom);
      nz_err <= 4'($urandom);
      nz_dat <= $urandom;
   end

   always @(posedge PCLK) begin
      if (!PENABLE) acnt <= 0;
      else          acnt <= acnt + 1;
      if (PENABLE && PWRITE && PSEL != 0 && acnt >= tgt_wait && !tgt_err)
         bfm_mem[PADDR] <= PWDATA;
   end

   always_comb begin
      PREADY  = nz_rdy;
      PSLVERR = nz_err;
      PRDATA  = nz_dat;
      for (int k = 0; k < 4; k++) begin
         if (PSEL[k]) begin
            PREADY[k]        = PENABLE && (acnt >= tgt_wait);
            PSLVERR[k]       = tgt_err;
            PRDATA[k*8 +: 8] = bfm_mem[PADDR];
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [256];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called just after a negedge with the bridge idle; returns likewise.
   task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input int waits, input logic serr);
      int n, pen_cnt, exp_n;
      logic exp_err;
      logic [7:0] exp_rd;
      logic [3:0] exp_sel;
      exp_sel = 4'b0001 << a[7:6];
      exp_err = serr || (waits > TO);
      exp_n   = 3 + ((waits > TO) ? TO : waits);
      exp_rd  = (w || exp_err) ? 8'h00 : ref_mem[a];
      if (w && !exp_err) ref_mem[a] = d;
      tgt_wait = waits;
      tgt_err  = serr;
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      chk("cmd_ready", cmd_ready, 1);
      @(negedge PCLK);
      cmd_valid = 0;
      n = 1;
      chk("setup_psel", PSEL, exp_sel);
      chk("setup_pen", PENABLE, 0);
      chk("paddr", PADDR, a);
      chk("pwrite", PWRITE, w);
      chk("pwdata", PWDATA, d);
      pen_cnt = 0;
      while (!rsp_valid && n < 40) begin
         @(negedge PCLK);
         n++;
         if (PENABLE) pen_cnt++;
      end
      chk("latency", n, exp_n);
      chk("pen_cycles", pen_cnt, exp_n - 2);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("psel_idle", PSEL, 0);
      chk("ready_at_rsp", cmd_ready, 1);
      @(negedge PCLK);
      chk("rsp_pulse", rsp_valid, 0);
      chk("rsp_hold", rsp_rdata, exp_rd);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a, d;
      logic w, serr;
      int waits, stray;
      logic [7:0] last_paddr3;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

      // reset
      repeat (3) @(negedge PCLK);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_psel", PSEL, 0);
      chk("rst_pen", PENABLE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      PRESET = 1;
      @(negedge PCLK);

      // directed: zero-wait write/read on slave 1
      xfer(1, 8'h43, 8'hA5, 0, 0);
      xfer(0, 8'h43, 8'h00, 0, 0);
      // wait states on slave 2
      xfer(1, 8'h80, 8'h3C, 0, 0);
      xfer(0, 8'h80, 8'h00, 3, 0);
      // timeout and last-allowed-cycle completion
      xfer(0, 8'h80, 8'h00, 100, 0);
      xfer(0, 8'h80, 8'h00, TO, 0);
      // slave error on slave 0
      xfer(1, 8'h10, 8'h99, 0, 0);
      xfer(0, 8'h10, 8'h00, 0, 1);

      // randomized transfers
      for (int i = 0; i < 25; i++) begin
         w = 1'($urandom);
         a = 8'($urandom);
         d = 8'($urandom);
         waits = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 4);
         serr = ($urandom_range(0, 7) == 0);
         xfer(w, a, d, waits, serr);
      end

      // reset in the middle of ACCESS
      tgt_wait = 5; tgt_err = 0;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 8'hC3; cmd_wdata = 8'h77;
      @(negedge PCLK);
      cmd_valid = 0;
      @(negedge PCLK);
      chk("rst_mid_pen", PENABLE, 1);
      PRESET = 0;
      @(negedge PCLK);
      chk("rst_mid_psel", PSEL, 0);
      chk("rst_mid_ctl", {PENABLE, PWRITE}, 0);
      chk("rst_mid_bus", {PADDR, PWDATA}, 0);
      chk("rst_mid_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      chk("rst_mid_ready", cmd_ready, 0);
      PRESET = 1;
      stray = 0;
      repeat (8) begin
         @(negedge PCLK);
         if (rsp_valid) stray++;
      end
      chk("rst_no_rsp", stray, 0);
      xfer(0, 8'hC3, 8'h00, 0, 0);
      xfer(1, 8'hC3, 8'h5E, 1, 0);
      xfer(0, 8'hC3, 8'h00, 2, 0);

      // back-to-back writes to slave 0
      begin
         int i, pend, pulses, last_acc;
         i = 0; pend = 0; pulses = 0; last_acc = -1;
         tgt_wait = 0; tgt_err = 0;
         cmd_valid = 1; cmd_write = 1; cmd_addr = 0; cmd_wdata = 0;
         for (int c = 0; c < 60 && pulses < 6; c++) begin
            if (pend != 0) begin
               pend = 0;
               i++;
               if (i < 6) begin
                  cmd_addr = 8'(i); cmd_wdata = 8'(i * i);
               end else cmd_valid = 0;
            end
            if (cmd_valid && cmd_ready) begin
               if (last_acc >= 0) chk("b2b_gap", c - last_acc, 3);
               last_acc = c;
               pend = 1;
               ref_mem[i] = 8'(i * i);
            end
            @(negedge PCLK);
            if (rsp_valid) begin
               pulses++;
               chk("b2b_err", rsp_err, 0);
            end
         end
         cmd_valid = 0;
         chk("b2b_pulses", pulses, 6);
         chk("b2b_accepts", i, 6);
         for (int k = 0; k < 6; k++) xfer(0, 8'(k), 8'h00, $urandom_range(0, 2), 0);
      end

      // decode errors on the three-slave instance
      last_paddr3 = 8'h00;
      for (int i = 0; i < 10; i++) begin
         logic [1:0] idx;
         a = (i < 2) ? 8'hC0 + 8'(i) : 8'($urandom);
         w = 1'($urandom);
         idx = a[7:6];
         c_valid = 1; c_write = w; c_addr = a; c_wdata = 8'($urandom);
         chk("c3_ready", c_ready, 1);
         @(negedge PCLK);
         c_valid = 0;
         if (idx == 2'd3) begin
            chk("dec_rsp", r_valid, 1);
            chk("dec_err", r_err, 1);
            chk("dec_rdata", r_rdata, 0);
            chk("dec_psel", {psel3, pen3}, 0);
            chk("dec_paddr", paddr3, last_paddr3);
         end else begin
            chk("c3_setup_psel", psel3, 3'b001 << idx);
            repeat (2) @(negedge PCLK);
            chk("c3_rsp", r_valid, 1);
            chk("c3_err", r_err, 0);
            chk("c3_rdata", r_rdata, w ? 8'h00 : 8'h10 + 8'(idx));
            last_paddr3 = a;
         end
         @(negedge PCLK);
         chk("c3_pulse", r_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
